// File: rtl/conv1d_stream.sv
// Streaming 1-D convolution: buffers a frame of input vectors, then emits one
// saturated result per cycle for every filter/position pair, filter-major.
module conv1d_stream #(
    parameter int FRAME_SIZE  = 50,
    parameter int VECTOR_SIZE = 1,
    parameter int NUM_FILTERS = 8,
    parameter int FILTER_SIZE = 3,
    parameter int SHIFT       = 0,
    parameter int RELU        = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [VECTOR_SIZE*8-1:0] data_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic signed [7:0]        data_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i,
    input  logic                     wt_wr_i,
    input  logic [$clog2(NUM_FILTERS*(FILTER_SIZE*VECTOR_SIZE+1))-1:0] wt_addr_i,
    input  logic signed [7:0]        wt_data_i,
    output logic                     err_o
);

    localparam int TAPS = FILTER_SIZE * VECTOR_SIZE;
    localparam int NWT  = NUM_FILTERS * TAPS;
    localparam int NTOT = NWT + NUM_FILTERS;
    localparam int AW   = $clog2(NTOT);
    localparam int BW   = $clog2(FRAME_SIZE);
    localparam int FW   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int ACCW = 16 + $clog2(TAPS + 1);

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(127);
    localparam logic signed [ACCW-1:0] SAT_MIN = -ACCW'(128);

    typedef enum logic {
        S_LOAD,
        S_COMPUTE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [7:0]        wts [NTOT];
    logic [VECTOR_SIZE*8-1:0] buf_mem [FRAME_SIZE];

    logic [BW-1:0] n_cnt;
    logic [BW-1:0] p_cnt;
    logic [BW-1:0] p_last;
    logic [FW-1:0] f_cnt;
    logic          issue_done;

    logic accept;
    logic frame_end;
    logic frame_long;
    logic advance;
    logic issue;
    logic issue_last;
    logic out_done;

    logic signed [ACCW-1:0]   acc_d;
    logic signed [15:0]       prod;
    logic [VECTOR_SIZE*8-1:0] row;
    logic [BW-1:0]            b_idx;
    logic [AW-1:0]            w_idx;

    logic                   s1_valid;
    logic                   s1_last;
    logic signed [ACCW-1:0] s1_acc;

    logic signed [ACCW-1:0] shifted;
    logic signed [ACCW-1:0] clipped;
    logic signed [7:0]      sat_res;

    assign ready_o    = (state_q == S_LOAD) && !rst_i;
    assign accept     = valid_i && ready_o;
    assign frame_end  = accept && (last_i || (n_cnt == BW'(FRAME_SIZE - 1)));
    assign frame_long = (int'(n_cnt) + 1) >= FILTER_SIZE;
    assign advance    = !valid_o || ready_i;
    assign issue      = (state_q == S_COMPUTE) && !issue_done && advance;
    assign issue_last = (f_cnt == FW'(NUM_FILTERS - 1)) && (p_cnt == p_last);
    assign out_done   = valid_o && ready_i && last_o;

    // Coefficient registers; only writable while the block is collecting a frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NTOT; i++) begin
                wts[i] <= '0;
            end
        end else if ((state_q == S_LOAD) && wt_wr_i && (int'(wt_addr_i) < NTOT)) begin
            wts[wt_addr_i] <= wt_data_i;
        end
    end

    // Frame buffer: each accepted beat lands at the current write index.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            buf_mem[n_cnt] <= data_i;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a long enough frame starts computing; the final handshake returns to loading.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (frame_end && frame_long) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (out_done) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Write index, filter/position issue counters and the short-frame error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_cnt      <= '0;
            p_cnt      <= '0;
            p_last     <= '0;
            f_cnt      <= '0;
            issue_done <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            err_o <= frame_end && !frame_long;
            if (accept) begin
                if (frame_end) begin
                    n_cnt <= '0;
                    if (frame_long) begin
                        p_last     <= BW'(int'(n_cnt) + 1 - FILTER_SIZE);
                        p_cnt      <= '0;
                        f_cnt      <= '0;
                        issue_done <= 1'b0;
                    end
                end else begin
                    n_cnt <= n_cnt + 1'b1;
                end
            end
            if (issue) begin
                if (issue_last) begin
                    issue_done <= 1'b1;
                end else if (p_cnt == p_last) begin
                    p_cnt <= '0;
                    f_cnt <= f_cnt + 1'b1;
                end else begin
                    p_cnt <= p_cnt + 1'b1;
                end
            end
        end
    end

    // Full-precision dot product of one filter with the window at the current position, all taps at once.
    always_comb begin
        acc_d = ACCW'(wts[AW'(NWT + int'(f_cnt))]);
        prod  = '0;
        row   = '0;
        b_idx = '0;
        w_idx = '0;
        for (int k = 0; k < FILTER_SIZE; k++) begin
            b_idx = BW'(int'(p_cnt) + k);
            row   = buf_mem[b_idx];
            for (int c = 0; c < VECTOR_SIZE; c++) begin
                w_idx = AW'((int'(f_cnt) * FILTER_SIZE + k) * VECTOR_SIZE + c);
                prod  = 16'(wts[w_idx]) * 16'($signed(row[c*8 +: 8]));
                acc_d = acc_d + ACCW'(prod);
            end
        end
    end

    // First pipeline stage holds the raw sum; the whole pipe freezes while the output is stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_acc   <= '0;
        end else if (advance) begin
            s1_valid <= issue;
            s1_last  <= issue && issue_last;
            if (issue) begin
                s1_acc <= acc_d;
            end
        end
    end

    // Scale down, optionally rectify, then clamp into the signed byte range.
    always_comb begin
        shifted = s1_acc >>> SHIFT;
        clipped = shifted;
        if ((RELU != 0) && shifted[ACCW-1]) begin
            clipped = '0;
        end
        if (clipped > SAT_MAX) begin
            sat_res = 8'sd127;
        end else if (clipped < SAT_MIN) begin
            sat_res = -8'sd128;
        end else begin
            sat_res = clipped[7:0];
        end
    end

    // Registered output stage; holds its value while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            data_o  <= '0;
        end else if (advance) begin
            valid_o <= s1_valid;
            last_o  <= s1_last;
            if (s1_valid) begin
                data_o <= sat_res;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream.sv
// Self-checking bench for conv1d_stream: two instances (plain and rectifying)
// share stimulus and are compared against a frame-level arithmetic model.
module tb_conv1d_stream;

    localparam int FRAME_SIZE  = 8;
    localparam int VECTOR_SIZE = 1;
    localparam int FILTER_SIZE = 3;
    localparam int NUM_FILTERS = 2;
    localparam int SHIFT       = 0;
    localparam int NADDR       = NUM_FILTERS * (FILTER_SIZE * VECTOR_SIZE + 1);
    localparam int AW          = $clog2(NADDR);
    localparam int BIAS_BASE   = NUM_FILTERS * FILTER_SIZE * VECTOR_SIZE;

    logic                     clk      = 1'b0;
    logic                     rst      = 1'b1;
    logic [VECTOR_SIZE*8-1:0] data_in  = '0;
    logic                     valid_in = 1'b0;
    logic                     last_in  = 1'b0;
    logic                     ready_in = 1'b1;
    logic                     wt_wr    = 1'b0;
    logic [AW-1:0]            wt_addr  = '0;
    logic signed [7:0]        wt_data  = '0;

    logic              ready_a, valid_a, last_a, err_a;
    logic signed [7:0] data_a;
    logic              ready_r, valid_r, last_r, err_r;
    logic signed [7:0] data_r;

    int checks   = 0;
    int failures = 0;
    int wmod [NADDR];
    int frame_q [$];
    int exp_lin [$];
    int exp_relu [$];

    conv1d_stream #(
        .FRAME_SIZE(FRAME_SIZE), .VECTOR_SIZE(VECTOR_SIZE), .NUM_FILTERS(NUM_FILTERS),
        .FILTER_SIZE(FILTER_SIZE), .SHIFT(SHIFT), .RELU(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_in), .valid_i(valid_in), .last_i(last_in),
        .ready_o(ready_a), .data_o(data_a), .valid_o(valid_a), .last_o(last_a),
        .ready_i(ready_in), .wt_wr_i(wt_wr), .wt_addr_i(wt_addr), .wt_data_i(wt_data),
        .err_o(err_a)
    );

    conv1d_stream #(
        .FRAME_SIZE(FRAME_SIZE), .VECTOR_SIZE(VECTOR_SIZE), .NUM_FILTERS(NUM_FILTERS),
        .FILTER_SIZE(FILTER_SIZE), .SHIFT(SHIFT), .RELU(1)
    ) u_relu (
        .clk_i(clk), .rst_i(rst), .data_i(data_in), .valid_i(valid_in), .last_i(last_in),
        .ready_o(ready_r), .data_o(data_r), .valid_o(valid_r), .last_o(last_r),
        .ready_i(ready_in), .wt_wr_i(wt_wr), .wt_addr_i(wt_addr), .wt_data_i(wt_data),
        .err_o(err_r)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic void buildExpected(input int len);
        exp_lin.delete();
        exp_relu.delete();
        for (int f = 0; f < NUM_FILTERS; f++) begin
            for (int p = 0; p <= len - FILTER_SIZE; p++) begin
                int acc;
                acc = wmod[BIAS_BASE + f];
                for (int k = 0; k < FILTER_SIZE; k++) begin
                    acc += wmod[f * FILTER_SIZE + k] * frame_q[p + k];
                end
                acc = acc >>> SHIFT;
                exp_lin.push_back(sat8(acc));
                exp_relu.push_back(sat8((acc < 0) ? 0 : acc));
            end
        end
    endfunction

    function automatic void loadRamp(input int n);
        frame_q.delete();
        for (int i = 1; i <= n; i++) frame_q.push_back(i);
    endfunction

    function automatic void loadConst(input int n, input int v);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(v);
    endfunction

    task automatic writeWeight(input int addr, input int val);
        wt_wr   = 1'b1;
        wt_addr = AW'(addr);
        wt_data = 8'(val);
        @(posedge clk); #1;
        wt_wr   = 1'b0;
        wmod[addr] = val;
    endtask

    task automatic applyStimulus(input int n_beats, input bit use_last);
        for (int i = 0; i < n_beats; i++) begin
            data_in  = 8'(frame_q[i]);
            valid_in = 1'b1;
            last_in  = use_last && (i == n_beats - 1);
            checkOutput("ready_o_beat", ready_a, 1);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = '0;
    endtask

    task automatic collectResults(input int n_exp, input bit stall, input bit poke, input int abort_at);
        int  got;
        int  cyc;
        int  first;
        int  stop_at;
        bit  was_stalled;
        got = 0;
        cyc = 0;
        first = -1;
        was_stalled = 1'b0;
        stop_at = (abort_at > 0) ? abort_at : n_exp;
        while (got < stop_at && cyc < 200) begin
            if (was_stalled) checkOutput("valid_held", valid_a, 1);
            if (valid_a === 1'b1 && first < 0) first = cyc;
            if (poke) begin
                wt_wr   = (cyc == 3);
                wt_addr = '0;
                wt_data = 8'sd77;
            end
            ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid_a === 1'b1) begin
                checkOutput("data_o", $signed(data_a), exp_lin[got]);
                checkOutput("data_o_relu", $signed(data_r), exp_relu[got]);
                checkOutput("last_o", last_a, (got == n_exp - 1) ? 1 : 0);
                checkOutput("valid_o_relu", valid_r, 1);
                if (ready_in) got++;
                was_stalled = !ready_in;
            end else begin
                was_stalled = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wt_wr    = 1'b0;
        ready_in = 1'b1;
        checkOutput("results_in_budget", got, stop_at);
        checkOutput("first_valid_latency", first, 2);
        if (abort_at == 0) begin
            checkOutput("ready_after_last", ready_a, 1);
            checkOutput("valid_after_last", valid_a, 0);
        end
    endtask

    task automatic runFrame(input int len, input bit use_last, input bit stall,
                            input bit poke, input int abort_at);
        buildExpected(len);
        applyStimulus(len, use_last);
        collectResults(exp_lin.size(), stall, poke, abort_at);
    endtask

    // Directed sequence followed by randomized frames, ending with a mid-frame reset.
    initial begin
        int errs;
        int vals;
        int rlow;
        int len;
        bit use_last;

        for (int i = 0; i < NADDR; i++) wmod[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ready_during_reset", ready_a, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", ready_a, 1);
        checkOutput("ready_after_reset_relu", ready_r, 1);
        checkOutput("valid_after_reset", valid_a, 0);
        checkOutput("err_after_reset", err_a, 0);

        $display("[TB] zero weights, ramp frame");
        loadRamp(8);
        runFrame(8, 1'b1, 1'b0, 1'b0, 0);

        $display("[TB] moving-sum filter and bias-only filter");
        writeWeight(0, 1);
        writeWeight(1, 1);
        writeWeight(2, 1);
        writeWeight(BIAS_BASE + 1, 5);
        loadRamp(8);
        runFrame(8, 1'b1, 1'b0, 1'b0, 0);

        $display("[TB] same frame with random backpressure and a blocked weight write");
        runFrame(8, 1'b1, 1'b1, 1'b1, 0);

        $display("[TB] short frame");
        frame_q.delete();
        frame_q.push_back(4);
        frame_q.push_back(5);
        applyStimulus(2, 1'b1);
        errs = 0;
        vals = 0;
        rlow = 0;
        for (int i = 0; i < 6; i++) begin
            errs += int'(err_a) + int'(err_r);
            vals += int'(valid_a);
            rlow += int'(!ready_a);
            @(posedge clk); #1;
        end
        checkOutput("short_err_pulses", errs, 2);
        checkOutput("short_no_valid", vals, 0);
        checkOutput("short_ready_kept", rlow, 0);
        loadRamp(8);
        runFrame(8, 1'b0, 1'b0, 1'b0, 0);

        $display("[TB] saturation frames");
        for (int i = 0; i < NADDR; i++) writeWeight(i, 127);
        loadConst(8, 127);
        runFrame(8, 1'b1, 1'b0, 1'b0, 0);
        loadConst(8, -128);
        runFrame(8, 1'b1, 1'b1, 1'b0, 0);

        $display("[TB] randomized frames");
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NADDR; i++) writeWeight(i, int'($urandom_range(0, 255)) - 128);
            len = int'($urandom_range(FILTER_SIZE, FRAME_SIZE));
            use_last = (len < FRAME_SIZE) ? 1'b1 : 1'($urandom_range(0, 1));
            frame_q.delete();
            for (int i = 0; i < len; i++) frame_q.push_back(int'($urandom_range(0, 255)) - 128);
            runFrame(len, use_last, 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("[TB] reset in the middle of a frame");
        for (int i = 0; i < NADDR; i++) writeWeight(i, 0);
        writeWeight(0, 1);
        writeWeight(1, 1);
        writeWeight(2, 1);
        writeWeight(BIAS_BASE + 1, 5);
        loadRamp(8);
        runFrame(8, 1'b1, 1'b0, 1'b0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("valid_after_abort", valid_a, 0);
        checkOutput("ready_in_abort_reset", ready_a, 0);
        rst = 1'b0;
        for (int i = 0; i < NADDR; i++) wmod[i] = 0;
        vals = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vals += int'(valid_a);
        end
        checkOutput("no_results_after_abort", vals, 0);
        checkOutput("ready_after_abort", ready_a, 1);
        loadRamp(8);
        runFrame(8, 1'b1, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
